// File: rtl/regfile_param_if.sv
// Register-file access bundle: two combinational read ports, one write port
// and the ready flag. master = decode/writeback side, slave = register file.
interface regfile_param_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 6
);
  logic [AWIDTH-1:0] ra1;
  logic [AWIDTH-1:0] ra2;
  logic [DWIDTH-1:0] rd1;
  logic [DWIDTH-1:0] rd2;
  logic [AWIDTH-1:0] wa;
  logic [DWIDTH-1:0] wd;
  logic              we;
  logic              ready;

  modport master (
    output ra1, ra2, wa, wd, we,
    input  rd1, rd2, ready
  );

  modport slave (
    input  ra1, ra2, wa, wd, we,
    output rd1, rd2, ready
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with sequenced clear-after-reset and ready flag.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_param #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 6,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_param_if.slave bus
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AWIDTH:0]   cnt;
  logic [AWIDTH:0]   cnt_nxt;
  logic              last_entry;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic              mem_we;
  logic [AWIDTH-1:0] mem_wa;
  logic [DWIDTH-1:0] mem_wd;

  assign last_entry = (cnt[AWIDTH-1:0] == {AWIDTH{1'b1}});

  // State register: reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + CNT_ONE;
        if (last_entry) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // Outputs and the single array write port, shared by the clear sequencer and user writes.
  always_comb begin
    bus.ready = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = bus.wa;
    mem_wd    = bus.wd;
    case (state)
      CLEAR: begin
        mem_we = !rst;
        mem_wa = cnt[AWIDTH-1:0];
        mem_wd = '0;
      end
      RUN: begin
        bus.ready = 1'b1;
        mem_we    = bus.we && !rst && !(ZERO_REG && (bus.wa == '0));
      end
      default: mem_we = 1'b0;
    endcase
  end

  // NOTE: the array has no reset; the clear sequencer zeroes it so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    bus.rd1 = mem[bus.ra1];
`ifdef REGFILE_BYPASS_EN
    if (bus.we && (bus.ra1 == bus.wa)) bus.rd1 = bus.wd;
`endif
    if ((state == CLEAR) || (ZERO_REG && (bus.ra1 == '0))) bus.rd1 = '0;
  end

  always_comb begin
    bus.rd2 = mem[bus.ra2];
`ifdef REGFILE_BYPASS_EN
    if (bus.we && (bus.ra2 == bus.wa)) bus.rd2 = bus.wd;
`endif
    if ((state == CLEAR) || (ZERO_REG && (bus.ra2 == '0))) bus.rd2 = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: two instances (ZERO_REG=1 and 0) share stimulus and are
// compared against a behavioural array model plus a directed vector table.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic [5:0]  ra1;
  logic [5:0]  ra2;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_param_if #(.DWIDTH(32), .AWIDTH(6)) bus_z ();
  regfile_param_if #(.DWIDTH(32), .AWIDTH(6)) bus_n ();

  assign bus_z.we  = we;   assign bus_n.we  = we;
  assign bus_z.wa  = wa;   assign bus_n.wa  = wa;
  assign bus_z.wd  = wd;   assign bus_n.wd  = wd;
  assign bus_z.ra1 = ra1;  assign bus_n.ra1 = ra1;
  assign bus_z.ra2 = ra2;  assign bus_n.ra2 = ra2;

  regfile_param #(.DWIDTH(32), .AWIDTH(6), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .bus(bus_z.slave)
  );
  regfile_param #(.DWIDTH(32), .AWIDTH(6), .ZERO_REG(1'b0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: index 0 is the ZERO_REG=1 instance, index 1 the ordinary one.
  logic [31:0] m_mem [2][64];
  bit          m_ready;
  int          m_clr;
  bit          zr [2] = '{1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int k, input logic [5:0] ra);
    if (!m_ready) return 32'h0;
    if (zr[k] && ra == 6'd0) return 32'h0;
    if (BYPASS && we && ra == wa) return wd;
    return m_mem[k][ra];
  endfunction

  // Clear is invisible until complete, so the model zeroes everything when it finishes.
  function automatic void model_update();
    if (rst) begin
      m_ready = 1'b0;
      m_clr   = 0;
    end else if (!m_ready) begin
      m_clr++;
      if (m_clr == 64) begin
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++)
          for (int e = 0; e < 64; e++) m_mem[k][e] = 32'h0;
      end
    end else if (we) begin
      for (int k = 0; k < 2; k++)
        if (!(zr[k] && wa == 6'd0)) m_mem[k][wa] = wd;
    end
  endfunction

  task automatic compare_model();
    check("rd1_z",   bus_z.rd1,   exp_rd(0, ra1));
    check("rd2_z",   bus_z.rd2,   exp_rd(0, ra2));
    check("rd1_n",   bus_n.rd1,   exp_rd(1, ra1));
    check("rd2_n",   bus_n.rd2,   exp_rd(1, ra2));
    check("ready_z", {31'b0, bus_z.ready}, {31'b0, m_ready});
    check("ready_n", {31'b0, bus_n.ready}, {31'b0, m_ready});
  endtask

  task automatic run_cycle(input bit do_check);
    @(negedge clk);
    if (do_check) compare_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_wait(output int edges);
    edges = 0;
    for (int i = 0; i < 200; i++) begin
      run_cycle(1'b1);
      edges++;
      if (bus_z.ready) break;
    end
  endtask

  task automatic sweep_reads();
    we = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ra1 = 6'(i);
      ra2 = 6'(63 - i);
      run_cycle(1'b1);
    end
  endtask

  typedef struct {
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [5:0]  ra1;
    logic [5:0]  ra2;
    logic [31:0] e1z;
    logic [31:0] e2z;
    logic [31:0] e1n;
    logic [31:0] e2n;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int edges;
    logic [31:0] bw_aaaa;
    logic [31:0] bw_1234;
    logic [31:0] bw_a5;
    logic [31:0] bw_zero;

    // Directed vectors, applied right after the first clear (all entries 0).
    bw_aaaa = BYPASS ? 32'hFFFFAAAA : 32'h0;
    bw_1234 = BYPASS ? 32'h12345678 : 32'h0;
    bw_a5   = BYPASS ? 32'hA5A50001 : 32'h0;
    bw_zero = BYPASS ? 32'h0 : 32'hFFFFAAAA;
    vecs[0] = '{1'b1, 6'd5,  32'hFFFFAAAA, 6'd5,  6'd5,  bw_aaaa, bw_aaaa, bw_aaaa, bw_aaaa};
    vecs[1] = '{1'b0, 6'd5,  32'h0,        6'd5,  6'd5,  32'hFFFFAAAA, 32'hFFFFAAAA, 32'hFFFFAAAA, 32'hFFFFAAAA};
    vecs[2] = '{1'b1, 6'd0,  32'h12345678, 6'd0,  6'd0,  32'h0, 32'h0, bw_1234, bw_1234};
    vecs[3] = '{1'b0, 6'd0,  32'h0,        6'd0,  6'd5,  32'h0, 32'hFFFFAAAA, 32'h12345678, 32'hFFFFAAAA};
    vecs[4] = '{1'b1, 6'd63, 32'hA5A50001, 6'd63, 6'd62, bw_a5, 32'h0, bw_a5, 32'h0};
    vecs[5] = '{1'b0, 6'd63, 32'h0,        6'd62, 6'd63, 32'h0, 32'hA5A50001, 32'h0, 32'hA5A50001};
    vecs[6] = '{1'b1, 6'd5,  32'h0,        6'd5,  6'd0,  bw_zero, 32'h0, bw_zero, 32'h12345678};
    vecs[7] = '{1'b0, 6'd5,  32'h0,        6'd5,  6'd0,  32'h0, 32'h0, 32'h0, 32'h12345678};

    m_ready = 1'b0;
    m_clr   = 0;
    for (int k = 0; k < 2; k++)
      for (int e = 0; e < 64; e++) m_mem[k][e] = 32'h0;

    // Reset for two cycles, then clear with writes hammering entry 63.
    rst = 1'b1; we = 1'b0; wa = 6'd0; wd = 32'h0; ra1 = 6'd0; ra2 = 6'd0;
    run_cycle(1'b0);
    ra1 = 6'd7; ra2 = 6'd63;
    run_cycle(1'b1);
    rst = 1'b0; we = 1'b1; wa = 6'd63; wd = 32'hDEADBEEF; ra1 = 6'd63; ra2 = 6'd1;
    clear_wait(edges);
    check("clear_latency", 32'(edges), 32'd64);
    sweep_reads();

    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      @(negedge clk);
      check($sformatf("vec%0d_rd1_z", i), bus_z.rd1, vecs[i].e1z);
      check($sformatf("vec%0d_rd2_z", i), bus_z.rd2, vecs[i].e2z);
      check($sformatf("vec%0d_rd1_n", i), bus_n.rd1, vecs[i].e1n);
      check($sformatf("vec%0d_rd2_n", i), bus_n.rd2, vecs[i].e2n);
      check($sformatf("vec%0d_ready", i), {31'b0, bus_z.ready}, 32'd1);
      @(posedge clk);
      model_update();
      #1;
    end

    // Dual-port independence: distinct values in 1..63, opposite-direction sweep.
    for (int i = 1; i < 64; i++) begin
      we = 1'b1; wa = 6'(i); wd = $urandom ^ 32'(i);
      ra1 = 6'($urandom_range(0, 63)); ra2 = 6'(i);
      run_cycle(1'b1);
    end
    sweep_reads();

    // Reset pulse at edge 30 of a clear, with writes to entry 5 attempted throughout.
    rst = 1'b1; we = 1'b1; wa = 6'd5; wd = 32'hCAFEF00D; ra1 = 6'd5; ra2 = 6'd63;
    run_cycle(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 29; i++) run_cycle(1'b1);
    rst = 1'b1;
    run_cycle(1'b1);
    rst = 1'b0;
    clear_wait(edges);
    check("midclear_latency", 32'(edges), 32'd64);
    sweep_reads();

    // Randomised traffic with rare resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      we  = $urandom_range(0, 1) == 1;
      wa  = 6'($urandom_range(0, 63));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      run_cycle(1'b1);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised two-read/one-write register file; generalised successor to the fixed 32-bit register file in the processor datapath. It adds configurable data width and depth, an optional hardwired-zero register 0, and a sequenced clear-after-reset with a `ready` flag. It also has an optional same-cycle write-to-read bypass. It sits between decode (read addresses) and writeback (write port).

## Interface

- `DWIDTH`, default 32, data width in bits.
- `AWIDTH`, default 6, address width; depth = 2^AWIDTH entries.
- `ZERO_REG`, default 1: 1 means register 0 always reads 0 and ignores writes; 0 means it is an ordinary register.

Ports:

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ra1`  in  AWIDTH  read address, port 1.
- `ra2`  in  AWIDTH  read address, port 2.
- `rd1`  out  DWIDTH  read data, port 1 (combinational from `ra1`).
- `rd2`  out  DWIDTH  read data, port 2 (combinational from `ra2`).
- `wa`  in  AWIDTH  write address.
- `wd`  in  DWIDTH  write data.
- `we`  in  1  write enable, sampled on the rising edge of `clk`.
- `ready`  out  1  high when clear is complete and writes are accepted.

## Operation

- States: CLEAR and RUN. A clear counter `cnt` is AWIDTH+1 bits wide.
- `rst` high at an edge:
  - state goes to CLEAR, `cnt` to 0, `ready` to 0.
  - Array contents are untouched on that edge.
- CLEAR with `rst` low, each edge:
  - `mem[cnt[AWIDTH-1:0]]` is set to 0 and `cnt` increments.
  - When `cnt` reaches 2^AWIDTH-1, the same edge clears the last entry, sets the state to RUN and `ready` to 1.
- CLEAR behaviour:
  - `we` is ignored; no user write ever lands during CLEAR.
  - `rd1` and `rd2` read 0 regardless of address.
- RUN:
  - `we`=1 at an edge writes `wd` to `mem[wa]`. If `ZERO_REG`=1 and `wa`=0, the write is dropped.
  - `rdN` = `mem[raN]`. If `ZERO_REG`=1 and `raN`=0, `rdN`=0.
- Both read ports may address the same entry or the write address; no conflicts, no stalls.
- Wrap-around: the address is exactly AWIDTH bits, so every code is a valid entry. There is no out-of-range case.

## Timing

- Reset values: `ready`=0, `rd1`=`rd2`=0, state CLEAR, `cnt`=0.
- Holding `rst` high keeps the block in CLEAR with `cnt`=0.
- Clear latency: `ready` rises on the 2^AWIDTH-th rising edge after the first edge with `rst` low. This is 64 edges for the defaults.
- `rst` asserted mid-clear or in RUN restarts the clear from entry 0 at that edge.
- Write latency:
  - Data is stored at the `we` edge.
  - Without bypass, a read of that address returns the new value from just after the edge.
  - In the write cycle itself, the read returns the old value.
- Read latency: combinational, zero cycles.
- Simultaneous `rst` and `we`: `rst` wins and the write is dropped.

## Configuration

- `REGFILE_BYPASS_EN` defined:
  - In RUN, if `we`=1 and `raN`=`wa`, then `rdN`=`wd` in the same cycle (write-through forwarding).
  - This does not apply when `ZERO_REG`=1 and the address is 0; that read stays 0.
  - No bypass in CLEAR.
- `REGFILE_BYPASS_EN` not defined: no forwarding; reads in the write cycle return the pre-write contents.

## Test plan

- Reset then clear: `rst`=1 for 2 cycles, then 0. Required: `ready`=0 for 63 edges, 1 at edge 64; all 64 entries then read 0 on both ports.
- Write/readback: in RUN write `wa`=5 `wd`=32'hFFFFAAAA, then `ra1`=`ra2`=5. Required: `rd1`=`rd2`=32'hFFFFAAAA the cycle after the write edge. The same cycle shows the old value 0 unless `REGFILE_BYPASS_EN` is defined, in which case it shows 32'hFFFFAAAA.
- Zero register: `ZERO_REG`=1, write `wa`=0 `wd`=32'h12345678. Required: `rd1`=0 for `ra1`=0, including the write cycle with bypass enabled. With `ZERO_REG`=0 the value reads back.
- Writes during clear: `we`=1 `wa`=63 `wd`=32'hDEADBEEF for every CLEAR cycle. Required: entry 63 reads 0 after `ready`; `rd1`=0 throughout CLEAR.
- Reset mid-clear: assert `rst` one cycle at edge 30 of the clear. Required: `ready` stays 0 and rises exactly 64 edges after `rst` deasserts. Entries written before that reset read 0.
- Dual-port independence: write distinct values to entries 1..63, then sweep `ra1` ascending and `ra2` descending. Required: each port returns its own entry's value every cycle.
